// File: rtl/sysid_checker_pkg.sv
// Shared types and widths for the sysid integrity checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, counter widths, data width, and a small
// helper that tells whether a state belongs to the timestamp word.
package sysid_checker_pkg;

  localparam int DATA_W = 32;
  localparam int TO_W   = 8;   // per-read timeout counter
  localparam int PER_W  = 24;  // recheck period counter
  localparam int LAT_W  = 2;   // read latency counter (0..3)

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_ID,
    ST_WAIT_ID,
    ST_REQ_TS,
    ST_WAIT_TS,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Word-select derived from state: the request/wait handling is shared by
  // both words and only this bit decides where data lands next.
  function automatic logic is_ts_state(state_t s);
    return (s == ST_REQ_TS) || (s == ST_WAIT_TS);
  endfunction

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
// Latency: n/a (wires only).
// Backpressure: slave stalls the master with sys_waitrequest.
//
// Signals: sys_address (word select), sys_read (strobe),
//          sys_waitrequest (slave stall), sys_readdata (read data).
interface sysid_checker_if;

  logic                                  sys_address;
  logic                                  sys_read;
  logic                                  sys_waitrequest;
  logic [sysid_checker_pkg::DATA_W-1:0]  sys_readdata;

  modport master (
    output sys_address,
    output sys_read,
    input  sys_waitrequest,
    input  sys_readdata
  );

  modport slave (
    input  sys_address,
    input  sys_read,
    output sys_waitrequest,
    output sys_readdata
  );

endinterface

// File: rtl/sysid_checker.sv
// Reads sysid words 0 (ID) and 1 (timestamp), compares with expected values, publishes flags.
// Latency: 4 edges from trigger to result with no stalls; +1 per waitrequest or latency cycle per word.
// Backpressure: holds sys_read while sys_waitrequest is high; aborts a read after TIMEOUT cycles.
//
// Ports:
//   clock, reset_n      system clock, async active-low reset
//   start               one-cycle pulse requesting a recheck (ignored while busy)
//   bus                 Avalon-MM master side of sysid_checker_if
//   busy                check sequence in progress
//   done                at least one check completed since reset
//   match               last completed check matched both words
//   timeout             last check aborted on timeout
//   captured_id/_ts     words captured by the last check
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXPECTED_ID    = 32'd0,
  parameter logic [DATA_W-1:0] EXPECTED_TS    = 32'd1586464125,
  parameter int unsigned       READ_LATENCY   = 0,
  parameter int unsigned       TIMEOUT        = 255,
  parameter int unsigned       RECHECK_PERIOD = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  sysid_checker_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic              timeout,
  output logic [DATA_W-1:0] captured_id,
  output logic [DATA_W-1:0] captured_ts
);

  localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT);
  // Wraps when READ_LATENCY is 0; the wait states are never entered then.
  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(READ_LATENCY - 1);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(RECHECK_PERIOD - 1);
  localparam bit               ZERO_LAT   = (READ_LATENCY == 0);
  localparam bit               RECHECK_EN = (RECHECK_PERIOD != 0);

  state_t           state;
  logic [TO_W-1:0]  to_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [PER_W-1:0] per_cnt;

  logic is_ts;
  logic in_req;
  logic in_wait;
  logic accept;
  logic capture_now;
  logic recheck_go;

  assign is_ts   = is_ts_state(state);
  assign in_req  = (state == ST_REQ_ID) || (state == ST_REQ_TS);
  assign in_wait = (state == ST_WAIT_ID) || (state == ST_WAIT_TS);
  assign accept  = in_req && !bus.sys_waitrequest;

  // Data is valid on the acceptance edge itself for zero latency, otherwise
  // on the edge where the latency count from acceptance completes.
  assign capture_now = (accept && ZERO_LAT) || (in_wait && (lat_cnt == LAT_LAST));

  // A start pulse and the period terminal count on the same edge both map
  // onto this single condition, so they can only launch one sequence.
  assign recheck_go = start || (RECHECK_EN && (per_cnt == PER_LAST));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      bus.sys_read    <= 1'b0;
      bus.sys_address <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      match           <= 1'b0;
      timeout         <= 1'b0;
      captured_id     <= '0;
      captured_ts     <= '0;
      to_cnt          <= '0;
      lat_cnt         <= '0;
      per_cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Boot check launches without waiting for start.
          state           <= ST_REQ_ID;
          bus.sys_read    <= 1'b1;
          bus.sys_address <= 1'b0;
          busy            <= 1'b1;
          to_cnt          <= '0;
        end

        ST_REQ_ID, ST_REQ_TS, ST_WAIT_ID, ST_WAIT_TS: begin
          if (to_cnt == TO_LIMIT) begin
            // Abort: captured words keep whatever already landed.
            state        <= ST_DONE;
            bus.sys_read <= 1'b0;
            busy         <= 1'b0;
            timeout      <= 1'b1;
            match        <= 1'b0;
            done         <= 1'b1;
            per_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if (capture_now) begin
              if (is_ts) begin
                captured_ts  <= bus.sys_readdata;
                bus.sys_read <= 1'b0;
                state        <= ST_CHECK;
              end else begin
                captured_id     <= bus.sys_readdata;
                bus.sys_read    <= 1'b1;
                bus.sys_address <= 1'b1;
                to_cnt          <= '0;
                state           <= ST_REQ_TS;
              end
            end else if (accept) begin
              bus.sys_read <= 1'b0;
              lat_cnt      <= '0;
              state        <= is_ts ? ST_WAIT_TS : ST_WAIT_ID;
            end else if (in_wait) begin
              lat_cnt <= lat_cnt + LAT_W'(1);
            end
          end
        end

        ST_CHECK: begin
          match   <= (captured_id == EXPECTED_ID) && (captured_ts == EXPECTED_TS);
          timeout <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
          per_cnt <= '0;
          state   <= ST_DONE;
        end

        ST_DONE: begin
          if (recheck_go) begin
            state           <= ST_REQ_ID;
            bus.sys_read    <= 1'b1;
            bus.sys_address <= 1'b0;
            busy            <= 1'b1;
            to_cnt          <= '0;
          end else if (RECHECK_EN) begin
            per_cnt <= per_cnt + PER_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Self-checking bench for sysid_checker: four instances cover defaults,
// stalls plus read latency, timeout, and periodic recheck.
module tb_sysid_checker;

  localparam logic [31:0] TS_OK = 32'd1586464125;
  localparam int NDUT = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [NDUT-1:0] rst_n_v = '0;
  logic [NDUT-1:0] start_v = '0;
  logic [NDUT-1:0] busy_v, done_v, match_v, to_v, read_v, addr_v;
  logic [31:0]     cid_v [NDUT];
  logic [31:0]     cts_v [NDUT];

  int checks = 0;
  int errors = 0;

  sysid_checker_if if_a ();
  sysid_checker_if if_b ();
  sysid_checker_if if_c ();
  sysid_checker_if if_d ();

  assign read_v = {if_d.sys_read, if_c.sys_read, if_b.sys_read, if_a.sys_read};
  assign addr_v = {if_d.sys_address, if_c.sys_address, if_b.sys_address, if_a.sys_address};

  // Slave models
  logic [31:0] id_a = 32'd0, ts_a = TS_OK, id_d = 32'd0;
  logic        wr_c = 1'b1;
  int          stall_n = 3;
  int          stall_cnt = 0;
  int          lat_cd = 0;
  logic        addr_q = 1'b0;

  assign if_a.sys_waitrequest = 1'b0;
  assign if_a.sys_readdata    = if_a.sys_address ? ts_a : id_a;

  // Instance b: waitrequest for stall_n cycles per read; data valid only on
  // the cycle before the edge that ends a 2-cycle latency.
  always @(posedge clock) begin
    if (if_b.sys_read && if_b.sys_waitrequest) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
    if (if_b.sys_read && !if_b.sys_waitrequest) begin
      lat_cd <= 2;
      addr_q <= if_b.sys_address;
    end else if (lat_cd != 0) begin
      lat_cd <= lat_cd - 1;
    end
  end
  assign if_b.sys_waitrequest = if_b.sys_read && (stall_cnt < stall_n);
  assign if_b.sys_readdata    = (lat_cd == 1) ? (addr_q ? TS_OK : 32'd0) : 32'hDEAD_BEEF;

  assign if_c.sys_waitrequest = wr_c;
  assign if_c.sys_readdata    = if_c.sys_address ? TS_OK : 32'd0;

  assign if_d.sys_waitrequest = 1'b0;
  assign if_d.sys_readdata    = if_d.sys_address ? TS_OK : id_d;

  sysid_checker dut_a (
    .clock(clock), .reset_n(rst_n_v[0]), .start(start_v[0]), .bus(if_a),
    .busy(busy_v[0]), .done(done_v[0]), .match(match_v[0]), .timeout(to_v[0]),
    .captured_id(cid_v[0]), .captured_ts(cts_v[0]));

  sysid_checker #(.READ_LATENCY(2)) dut_b (
    .clock(clock), .reset_n(rst_n_v[1]), .start(start_v[1]), .bus(if_b),
    .busy(busy_v[1]), .done(done_v[1]), .match(match_v[1]), .timeout(to_v[1]),
    .captured_id(cid_v[1]), .captured_ts(cts_v[1]));

  sysid_checker #(.TIMEOUT(10)) dut_c (
    .clock(clock), .reset_n(rst_n_v[2]), .start(start_v[2]), .bus(if_c),
    .busy(busy_v[2]), .done(done_v[2]), .match(match_v[2]), .timeout(to_v[2]),
    .captured_id(cid_v[2]), .captured_ts(cts_v[2]));

  sysid_checker #(.RECHECK_PERIOD(20)) dut_d (
    .clock(clock), .reset_n(rst_n_v[3]), .start(start_v[3]), .bus(if_d),
    .busy(busy_v[3]), .done(done_v[3]), .match(match_v[3]), .timeout(to_v[3]),
    .captured_id(cid_v[3]), .captured_ts(cts_v[3]));

  typedef struct {
    logic        done;
    logic        match;
    logic        timeout;
    logic [31:0] id;
    logic [31:0] ts;
    int          elapsed;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    bit          two_pulse;
    logic        exp_match;
  } vec_t;
  vec_t tbl [5];

  logic rd_trace [0:127];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic m, input logic t, input logic [31:0] id,
                            input logic [31:0] ts, input int el);
    exp_t e;
    e.done = 1'b1; e.match = m; e.timeout = t; e.id = id; e.ts = ts; e.elapsed = el;
    sb.push_back(e);
  endtask

  // Waits for busy to rise and fall on instance d, then pops and compares.
  task automatic run_wait(input int d, input int budget, input bit hold_chk,
                          input int pulse_len, input string name);
    exp_t e;
    int   t0, glitches, el;
    bit   seen, fin;
    logic m0;
    t0 = cyc; seen = 0; fin = 0; glitches = 0; m0 = match_v[d];
    for (int i = 0; i < 128; i++) rd_trace[i] = 1'b0;
    for (int k = 0; k < budget && !fin; k++) begin
      @(negedge clock);
      if (pulse_len != 0 && k + 1 == pulse_len) start_v[d] = 1'b0;
      el = cyc - t0;
      if (el < 128) rd_trace[el] = read_v[d];
      if (busy_v[d]) seen = 1;
      else if (seen) fin = 1;
      if (!fin && hold_chk && (done_v[d] !== 1'b1 || match_v[d] !== m0)) glitches++;
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s.complete: no completion within %0d cycles", name, budget);
    end
    e = sb.pop_front();
    chk({name, ".elapsed"}, cyc - t0, e.elapsed);
    chk({name, ".done"}, {31'd0, done_v[d]}, {31'd0, e.done});
    chk({name, ".match"}, {31'd0, match_v[d]}, {31'd0, e.match});
    chk({name, ".timeout"}, {31'd0, to_v[d]}, {31'd0, e.timeout});
    chk({name, ".captured_id"}, cid_v[d], e.id);
    chk({name, ".captured_ts"}, cts_v[d], e.ts);
    chk({name, ".sys_read"}, {31'd0, read_v[d]}, 32'd0);
    if (hold_chk) chk({name, ".glitches"}, glitches, 0);
  endtask

  task automatic quiet(input int d, input int n, input string name);
    int cnt;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (busy_v[d]) cnt++;
    end
    chk({name, ".no_extra_seq"}, cnt, 0);
  endtask

  task automatic chk_zero(input int d, input string name);
    chk({name, ".busy"}, {31'd0, busy_v[d]}, 32'd0);
    chk({name, ".done"}, {31'd0, done_v[d]}, 32'd0);
    chk({name, ".match"}, {31'd0, match_v[d]}, 32'd0);
    chk({name, ".timeout"}, {31'd0, to_v[d]}, 32'd0);
    chk({name, ".sys_read"}, {31'd0, read_v[d]}, 32'd0);
    chk({name, ".sys_address"}, {31'd0, addr_v[d]}, 32'd0);
    chk({name, ".captured_id"}, cid_v[d], 32'd0);
    chk({name, ".captured_ts"}, cts_v[d], 32'd0);
  endtask

  initial begin
    int rd_idx [6];
    logic rd_exp [6];
    tbl[0] = '{32'd0,         TS_OK,         1'b0, 1'b1};
    tbl[1] = '{32'd0,         32'd1586464126, 1'b0, 1'b0};
    tbl[2] = '{32'd5,         TS_OK,         1'b1, 1'b0};
    tbl[3] = '{32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0};
    tbl[4] = '{32'd0,         TS_OK,         1'b1, 1'b1};

    repeat (3) @(negedge clock);
    for (int d = 0; d < NDUT; d++) chk_zero(d, $sformatf("reset%0d", d));

    // Table-driven: row 0 is the boot check, later rows use start.
    for (int i = 0; i < 5; i++) begin
      id_a = tbl[i].id;
      ts_a = tbl[i].ts;
      expect_res(tbl[i].exp_match, 1'b0, tbl[i].id, tbl[i].ts, 4);
      if (i == 0) begin
        rst_n_v[0] = 1'b1;
        run_wait(0, 20, 1'b0, 0, "row0_boot");
      end else begin
        start_v[0] = 1'b1;
        run_wait(0, 20, 1'b0, tbl[i].two_pulse ? 2 : 1, $sformatf("row%0d", i));
      end
      quiet(0, 6, $sformatf("row%0d", i));
    end

    // Three stall cycles per read plus two latency cycles per word.
    stall_n = 3;
    expect_res(1'b1, 1'b0, 32'd0, TS_OK, 14);
    rst_n_v[1] = 1'b1;
    run_wait(1, 40, 1'b0, 0, "lat_boot");
    rd_idx = '{4, 5, 6, 7, 11, 12};
    rd_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++)
      chk($sformatf("lat_boot.sys_read@%0d", rd_idx[i]), {31'd0, rd_trace[rd_idx[i]]},
          {31'd0, rd_exp[i]});

    // Reset while waiting on the timestamp latency.
    stall_n = 0;
    @(negedge clock);
    start_v[1] = 1'b1;
    @(negedge clock);
    start_v[1] = 1'b0;
    repeat (4) @(negedge clock);
    chk("mid.in_wait_ts.addr", {31'd0, addr_v[1]}, 32'd1);
    chk("mid.in_wait_ts.read", {31'd0, read_v[1]}, 32'd0);
    #1 rst_n_v[1] = 1'b0;
    #1 chk_zero(1, "mid_reset");
    repeat (3) @(negedge clock);
    expect_res(1'b1, 1'b0, 32'd0, TS_OK, 8);
    rst_n_v[1] = 1'b1;
    run_wait(1, 30, 1'b0, 0, "mid_reboot");

    // Stuck waitrequest, then recovery via start.
    wr_c = 1'b1;
    expect_res(1'b0, 1'b1, 32'd0, 32'd0, 12);
    rst_n_v[2] = 1'b1;
    run_wait(2, 40, 1'b0, 0, "to_boot");
    chk("to_boot.sys_read@11", {31'd0, rd_trace[11]}, 32'd1);
    chk("to_boot.sys_read@12", {31'd0, rd_trace[12]}, 32'd0);
    wr_c = 1'b0;
    repeat (2) @(negedge clock);
    expect_res(1'b1, 1'b0, 32'd0, TS_OK, 4);
    start_v[2] = 1'b1;
    run_wait(2, 20, 1'b0, 1, "to_recover");

    // Periodic recheck: boot, automatic recheck with changed ID, then a
    // start pulse coinciding with the terminal count.
    id_d = 32'd0;
    expect_res(1'b1, 1'b0, 32'd0, TS_OK, 4);
    rst_n_v[3] = 1'b1;
    run_wait(3, 20, 1'b0, 0, "per_boot");
    id_d = 32'd5;
    expect_res(1'b0, 1'b0, 32'd5, TS_OK, 23);
    run_wait(3, 60, 1'b1, 0, "per_recheck");
    id_d = 32'd0;
    repeat (19) @(negedge clock);
    expect_res(1'b1, 1'b0, 32'd0, TS_OK, 4);
    start_v[3] = 1'b1;
    run_wait(3, 20, 1'b1, 1, "per_coinc");
    quiet(3, 15, "per_coinc");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Boot-time and periodic integrity checker for the system-ID peripheral. Acts as a single Avalon-MM read master on the sysid control slave: reads word 0 (system ID) and word 1 (build timestamp), compares both against expected values, and publishes registered status flags and captured words. Sits beside the Nios II on the system interconnect and drives a board-level "wrong bitstream / stale software" indicator.

## Interface
- EXPECTED_ID, 32'd0: value required at sysid address 0
- EXPECTED_TS, 32'd1586464125: value required at sysid address 1
- READ_LATENCY, 0: cycles from read acceptance to valid readdata (0..3); 0 means readdata is sampled on the acceptance edge
- TIMEOUT, 255: maximum cycles spent waiting on one read (waitrequest plus latency) before aborting; 8-bit counter
- RECHECK_PERIOD, 0: cycles between automatic rechecks after DONE; 0 disables (boot check only); 24-bit counter
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; requests a new check (ignored while busy)
- sys_address  out  1  sysid word select
- sys_read  out  1  read strobe
- sys_waitrequest  in  1  slave stall; tie 0 for the combinational sysid slave
- sys_readdata  in  32  sysid read data
- busy  out  1  check sequence in progress
- done  out  1  at least one check completed since reset
- match  out  1  last completed check: both words equal expected
- timeout  out  1  last check aborted on TIMEOUT
- captured_id  out  32  word 0 from last check
- captured_ts  out  32  word 1 from last check

## Operation
- States: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, CHECK, DONE.
- Reset values: state IDLE; sys_read 0, sys_address 0, busy 0, done 0, match 0, timeout 0, captured_id 0, captured_ts 0; all counters 0.
- IDLE: unconditionally advances to REQ_ID on first edge after reset release (automatic boot check).
- REQ_ID: sys_read=1, sys_address=0. Read accepted on an edge with sys_waitrequest=0. READ_LATENCY=0: capture sys_readdata into captured_id on that edge, go REQ_TS. Else go WAIT_ID.
- WAIT_ID: sys_read=0; count READ_LATENCY cycles from acceptance; capture on the edge where the count is reached; go REQ_TS.
- REQ_TS / WAIT_TS: identical with sys_address=1, capture into captured_ts; then CHECK.
- CHECK: one cycle; match <= (captured_id==EXPECTED_ID)&&(captured_ts==EXPECTED_TS); timeout <= 0; done <= 1; go DONE.
- Timeout: a single per-read counter cleared on entering REQ_ID/REQ_TS, incremented every cycle in REQ_*/WAIT_*; reaching TIMEOUT drops sys_read, sets timeout=1, match=0, done=1, goes DONE. captured_* keep whatever was captured.
- DONE: busy=0. start pulse -> REQ_ID. RECHECK_PERIOD>0: period counter runs in DONE; at terminal count -> REQ_ID. start and terminal count on the same edge: one check only.
- busy=1 in every state except DONE; start is ignored when busy.
- match, timeout, done, captured_* hold during a recheck until its CHECK or timeout updates them; no glitch to 0.
- reset_n asserted mid-sequence: everything returns to reset values immediately; no partial capture survives; a fresh boot check follows release.

## Timing
- sys_read, sys_address registered; no combinational path from sys_waitrequest/sys_readdata to outputs.
- READ_LATENCY=0, waitrequest=0: edge1 REQ_ID, edge2 capture ID -> REQ_TS, edge3 capture TS -> CHECK, edge4 done/match valid. Boot result 4 cycles after first edge post-release.
- Each additional waitrequest cycle or latency cycle adds one cycle per word.
- Recheck from DONE via start: start sampled on edge N, sys_read high after edge N.

## Structure
- Shared package sysid_checker_pkg: state enum, counter width localparams (8-bit timeout, 24-bit period, 2-bit latency).
- Single module; no sub-module warranted. The read-acceptance/latency logic is shared by both words via a word-select bit rather than duplicated.

## Test plan
- Combinational sysid model (addr0->0, addr1->1586464125), defaults -> done=1, match=1, timeout=0 exactly 4 edges after reset release; captured_ts=1586464125.
- Model returning 1586464126 at addr 1 -> match=0, timeout=0, captured_ts=1586464126.
- waitrequest held 3 cycles on each read, READ_LATENCY=2 -> done at edge 14; correct captures; sys_read low during latency wait.
- waitrequest stuck high, TIMEOUT=10 -> timeout=1, match=0, done=1, sys_read low at edge 12; later start with waitrequest released -> match=1, timeout=0.
- RECHECK_PERIOD=20, ID changed to 5 between checks -> second check flips match 1->0 without done or match glitching mid-sequence; start coincident with terminal count yields one sequence.
- reset_n asserted while in WAIT_TS -> all outputs 0 asynchronously; fresh boot check completes normally after release.
